// File: rtl/dac_sample_feeder.sv
// Sample-rate front end for the DAC core: valid/ready ingress into a small FIFO,
// one code released per programmable tick, last code held and underflow flagged on starvation.
module dac_sample_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         rate_div,
    input  logic                     clr_flags,
    output logic [DATA_W-1:0]        dac_code,
    output logic                     dac_strobe,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [DATA_W-1:0]  MIDSCALE   = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DIV_W-1:0]  tick_cnt;
    logic              tick;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign in_ready   = (fifo_level != LEVEL_FULL);
    assign fifo_empty = (fifo_level == '0);
    assign push       = in_valid && in_ready;
    // >= rather than == so a live shrink of rate_div below the count still ticks
    assign tick       = enable && (tick_cnt >= rate_div);
    // Pop decision uses the pre-push level: no write-to-read bypass
    assign pop        = tick && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_code   <= MIDSCALE;
            dac_strobe <= 1'b0;
        end else begin
            dac_strobe <= pop;
            if (pop) begin
                dac_code <= mem[rd_ptr];
            end
        end
    end

    // A starved tick outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (tick && fifo_empty) begin
            underflow <= 1'b1;
        end else if (clr_flags) begin
            underflow <= 1'b0;
        end
    end

endmodule
